// File: rtl/reset_shutdown_sequence.sv
// rtl/reset_shutdown_sequence.sv - orderly reset-assertion (shutdown) sequencer
//
// Quiesces the processor with a req/ack handshake bounded by a timeout. It then
// asserts resets in reverse dependency order (processor, peripheral,
// interconnect), holds them, and on restart releases them in forward order.
// The reset outputs are OR'd externally with the power-on sequencer outputs.
//
// Ports:
//   clk              slowest sync clock
//   sync_reset       synchronous active-high reset
//   shutdown_req     start a shutdown sequence (sampled only in RUN)
//   restart          release resets again (sampled only in OFF)
//   quiesce_ack      processor has drained outstanding traffic
//   quiesce_req      request to processor to quiesce
//   processor_reset  active-high processor domain resets
//   periferal_reset  active-high peripheral domain resets
//   intercnct_reset  active-high interconnect domain resets
//   busy             sequencer is not in RUN
//   off              sequencer is parked in OFF
//   timeout_flag     sticky: last quiesce ended by timeout
//   done             one-cycle pulse on return to RUN
module reset_shutdown_sequence #(
    parameter int NO_INTERCNCT    = 1,
    parameter int NO_PERIFERAL    = 1,
    parameter int NO_PROCESSOR    = 1,
    parameter int QUIESCE_TIMEOUT = 256,
    parameter int STEP_CYCLES     = 32,
    parameter int HOLD_CYCLES     = 128
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic                    shutdown_req,
    input  logic                    restart,
    input  logic                    quiesce_ack,
    output logic                    quiesce_req,
    output logic [NO_PROCESSOR-1:0] processor_reset,
    output logic [NO_PERIFERAL-1:0] periferal_reset,
    output logic [NO_INTERCNCT-1:0] intercnct_reset,
    output logic                    busy,
    output logic                    off,
    output logic                    timeout_flag,
    output logic                    done
);

    localparam int MAX_QS  = (QUIESCE_TIMEOUT > STEP_CYCLES) ? QUIESCE_TIMEOUT : STEP_CYCLES;
    localparam int MAX_CNT = (MAX_QS > HOLD_CYCLES) ? MAX_QS : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] QUIESCE_LAST = CW'(QUIESCE_TIMEOUT - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        QUIESCE    = 3'd1,
        PROC_DOWN  = 3'd2,
        PERIF_DOWN = 3'd3,
        HOLD       = 3'd4,
        OFF        = 3'd5,
        ICN_UP     = 3'd6,
        PERIF_UP   = 3'd7
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state           <= RUN;
            counter         <= '0;
            quiesce_req     <= 1'b0;
            processor_reset <= '0;
            periferal_reset <= '0;
            intercnct_reset <= '0;
            timeout_flag    <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (shutdown_req) begin
                        state        <= QUIESCE;
                        counter      <= '0;
                        quiesce_req  <= 1'b1;
                        timeout_flag <= 1'b0;
                    end
                end
                QUIESCE: begin
                    // ack wins over a coinciding timeout, leaving timeout_flag clear
                    if (quiesce_ack || counter == QUIESCE_LAST) begin
                        if (!quiesce_ack) begin
                            timeout_flag <= 1'b1;
                        end
                        state           <= PROC_DOWN;
                        counter         <= '0;
                        quiesce_req     <= 1'b0;
                        processor_reset <= '1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                PROC_DOWN: begin
                    if (counter == STEP_LAST) begin
                        state           <= PERIF_DOWN;
                        counter         <= '0;
                        periferal_reset <= '1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                PERIF_DOWN: begin
                    if (counter == STEP_LAST) begin
                        state           <= HOLD;
                        counter         <= '0;
                        intercnct_reset <= '1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                HOLD: begin
                    if (counter == HOLD_LAST) begin
                        state   <= OFF;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                OFF: begin
                    processor_reset <= '1;
                    periferal_reset <= '1;
                    if (restart) begin
                        state           <= ICN_UP;
                        counter         <= '0;
                        intercnct_reset <= '0;
                    end else begin
                        intercnct_reset <= '1;
                    end
                end
                ICN_UP: begin
                    if (counter == STEP_LAST) begin
                        state           <= PERIF_UP;
                        counter         <= '0;
                        periferal_reset <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                PERIF_UP: begin
                    if (counter == STEP_LAST) begin
                        state           <= RUN;
                        counter         <= '0;
                        processor_reset <= '0;
                        done            <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state   <= RUN;
                    counter <= '0;
                end
            endcase
        end
    end

    assign busy = (state != RUN);
    assign off  = (state == OFF);

endmodule

// File: tb/tb_reset_shutdown_sequence.sv
// tb/tb_reset_shutdown_sequence.sv - randomized bench with timeline reference model
module tb_reset_shutdown_sequence;

    localparam int NI = 2;
    localparam int NP = 3;
    localparam int NC = 1;
    localparam int QT = 256;
    localparam int ST = 32;
    localparam int HC = 128;
    localparam int NUM_EDGES = 24000;

    logic          clk = 1'b0;
    logic          sync_reset = 1'b1;
    logic          shutdown_req = 1'b0;
    logic          restart = 1'b0;
    logic          quiesce_ack = 1'b0;
    logic          quiesce_req;
    logic [NC-1:0] processor_reset;
    logic [NP-1:0] periferal_reset;
    logic [NI-1:0] intercnct_reset;
    logic          busy;
    logic          off;
    logic          timeout_flag;
    logic          done;

    reset_shutdown_sequence #(
        .NO_INTERCNCT   (NI),
        .NO_PERIFERAL   (NP),
        .NO_PROCESSOR   (NC),
        .QUIESCE_TIMEOUT(QT),
        .STEP_CYCLES    (ST),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .shutdown_req   (shutdown_req),
        .restart        (restart),
        .quiesce_ack    (quiesce_ack),
        .quiesce_req    (quiesce_req),
        .processor_reset(processor_reset),
        .periferal_reset(periferal_reset),
        .intercnct_reset(intercnct_reset),
        .busy           (busy),
        .off            (off),
        .timeout_flag   (timeout_flag),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at edge %0d: got %0h expected %0h", tag, m_edge, obs, exp);
        end
    endtask

    // Reference model: phase plus the edge numbers at which each phase began.
    // Domain transitions are placed by arithmetic offsets from those marks.
    // phase: 0 running, 1 quiescing, 2 going down, 3 off, 4 coming up
    int m_edge  = 0;
    int m_phase = 0;
    int t_q = 0, t_p = 0, t_r = 0;
    bit m_to = 0, m_done = 0;
    int ack_mode = 0;
    int timeouts = 0, acks = 0, coincide = 0, restarts = 0, hold_resets = 0;
    bit hold_rst_pending = 1;

    task automatic model_edge(input bit rst, input bit sd, input bit rs, input bit ack);
        m_edge++;
        m_done = 0;
        if (rst) begin
            if (m_phase == 2 && m_edge > t_p + 2 * ST) hold_resets++;
            m_phase = 0;
            m_to    = 0;
        end else begin
            case (m_phase)
                0: if (sd) begin
                    m_phase  = 1;
                    t_q      = m_edge;
                    m_to     = 0;
                    ack_mode = $urandom_range(0, 3);
                end
                1: if (ack) begin
                    if (m_edge == t_q + QT) coincide++;
                    acks++;
                    m_phase = 2;
                    t_p     = m_edge;
                end else if (m_edge == t_q + QT) begin
                    timeouts++;
                    m_to    = 1;
                    m_phase = 2;
                    t_p     = m_edge;
                end
                2: if (m_edge == t_p + 2 * ST + HC) m_phase = 3;
                3: if (rs) begin
                    restarts++;
                    m_phase = 4;
                    t_r     = m_edge;
                end
                default: if (m_edge == t_r + 2 * ST) begin
                    m_phase = 0;
                    m_done  = 1;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        bit e_proc, e_peri, e_icn;
        e_proc = (m_phase >= 2);
        e_peri = (m_phase == 2 && m_edge >= t_p + ST) || m_phase == 3 ||
                 (m_phase == 4 && m_edge < t_r + ST);
        e_icn  = (m_phase == 2 && m_edge >= t_p + 2 * ST) || m_phase == 3;
        check("quiesce_req", 32'(quiesce_req), 32'(m_phase == 1));
        check("processor_reset", 32'(processor_reset), e_proc ? 32'((1 << NC) - 1) : 32'd0);
        check("periferal_reset", 32'(periferal_reset), e_peri ? 32'((1 << NP) - 1) : 32'd0);
        check("intercnct_reset", 32'(intercnct_reset), e_icn ? 32'((1 << NI) - 1) : 32'd0);
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("off", 32'(off), 32'(m_phase == 3));
        check("timeout_flag", 32'(timeout_flag), 32'(m_to));
        check("done", 32'(done), 32'(m_done));
    endtask

    initial begin
        bit rst, sd, rs, ack;
        int ne;
        // reset for two edges, then check reset values
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sync_reset = 1'b1;
            @(posedge clk);
            model_edge(1'b1, 1'b0, 1'b0, 1'b0);
            #1 compare_all();
        end
        for (int i = 0; i < NUM_EDGES; i++) begin
            @(negedge clk);
            ne  = m_edge + 1;
            sd  = ($urandom_range(0, 39) == 0);
            rs  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 5999) == 0);
            if (m_phase == 1) begin
                case (ack_mode)
                    0: ack = 1'b0;
                    1: ack = ($urandom_range(0, 49) == 0);
                    2: ack = (ne == t_q + QT);
                    default: ack = (ne == t_q + 5);
                endcase
            end else begin
                ack = ($urandom_range(0, 7) == 0);
            end
            // one directed reset in the middle of the hold window
            if (hold_rst_pending && m_phase == 2 && ne == t_p + 2 * ST + 10) begin
                rst = 1'b1;
                hold_rst_pending = 0;
            end
            sync_reset   = rst;
            shutdown_req = sd;
            restart      = rs;
            quiesce_ack  = ack;
            @(posedge clk);
            model_edge(rst, sd, rs, ack);
            #1 compare_all();
        end
        // scenario coverage: each path must have been exercised
        check("seen_timeout", 32'(timeouts > 0), 32'd1);
        check("seen_ack", 32'(acks > 0), 32'd1);
        check("seen_coincide", 32'(coincide > 0), 32'd1);
        check("seen_restart", 32'(restarts > 0), 32'd1);
        check("seen_hold_reset", 32'(hold_resets > 0), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
